// File: rtl/disparity_hole_fill.sv
// Disparity hole filler: replaces rejected (zero) disparities with the last valid value
// on the same row, tags row/frame boundaries and reports per-row and per-frame hole counts.
module disparity_hole_fill #(
   parameter  int D            = 64,
   parameter  int M            = 450,
   parameter  int R            = 375,
   parameter  int FILL_DEFAULT = 0,
   localparam int DBIT         = $clog2(D),
   localparam int RHW          = $clog2(M + 1),
   localparam int FHW          = $clog2(M * R + 1)
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_en_fill,
   input  logic            i_dval,
   input  logic [DBIT-1:0] i_data,
   output logic            o_dval,
   output logic [DBIT-1:0] o_data,
   output logic            o_hole,
   output logic            o_sol,
   output logic            o_eol,
   output logic            o_sof,
   output logic            o_eof,
   output logic [RHW-1:0]  o_row_holes,
   output logic [FHW-1:0]  o_frame_holes,
   output logic            o_stat_vld
);

   localparam int CW = (M > 1) ? $clog2(M) : 1;
   localparam int RW = (R > 1) ? $clog2(R) : 1;
   localparam logic [CW-1:0]   COL_LAST = CW'(M - 1);
   localparam logic [RW-1:0]   ROW_LAST = RW'(R - 1);
   localparam logic [DBIT-1:0] FILL_VAL = DBIT'(FILL_DEFAULT);

   typedef enum logic {
      ROW_START = 1'b0,
      IN_ROW    = 1'b1
   } state_t;

   state_t          state_r;
   state_t          state_s;
   logic [CW-1:0]   col_r;
   logic [CW-1:0]   col_s;
   logic [RW-1:0]   row_r;
   logic [RW-1:0]   row_s;
   logic [DBIT-1:0] last_r;
   logic [RHW-1:0]  row_cnt_r;
   logic [RHW-1:0]  row_sum_s;
   logic [FHW-1:0]  frame_cnt_r;
   logic [FHW-1:0]  frame_sum_s;
   logic            sol_s;
   logic            eol_s;
   logic            sof_s;
   logic            eof_s;
   logic            hole_s;
   logic [DBIT-1:0] fill_s;
   logic [DBIT-1:0] data_s;

   // Pixel classification, fill selection, hole sums, position and next-state logic
   always_comb begin
      sol_s       = (col_r == {CW{1'b0}});
      eol_s       = (col_r == COL_LAST);
      sof_s       = sol_s && (row_r == {RW{1'b0}});
      eof_s       = eol_s && (row_r == ROW_LAST);
      hole_s      = (i_data == {DBIT{1'b0}});
      fill_s      = FILL_VAL;
      data_s      = i_data;
      state_s     = state_r;
      col_s       = col_r;
      row_s       = row_r;

      case (state_r)
         ROW_START: fill_s = FILL_VAL;
         IN_ROW:    fill_s = last_r;
         default:   fill_s = FILL_VAL;
      endcase

      if (hole_s) begin
         if (i_en_fill) begin
            data_s = fill_s;
         end else begin
            data_s = {DBIT{1'b0}};
         end
      end else begin
         data_s = i_data;
      end

      // Counters restart on the first pixel of their row/frame, counting that pixel too
      row_sum_s   = (sol_s ? {RHW{1'b0}} : row_cnt_r) + RHW'(hole_s);
      frame_sum_s = (sof_s ? {FHW{1'b0}} : frame_cnt_r) + FHW'(hole_s);

      if (i_dval) begin
         if (eol_s) begin
            state_s = ROW_START;
            col_s   = {CW{1'b0}};
            if (row_r == ROW_LAST) begin
               row_s = {RW{1'b0}};
            end else begin
               row_s = row_r + RW'(1);
            end
         end else begin
            col_s = col_r + CW'(1);
            row_s = row_r;
            if (!hole_s) begin
               state_s = IN_ROW;
            end else begin
               state_s = state_r;
            end
         end
      end else begin
         state_s = state_r;
      end
   end

   // FSM state register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r <= ROW_START;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath, counters and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         col_r         <= {CW{1'b0}};
         row_r         <= {RW{1'b0}};
         last_r        <= FILL_VAL;
         row_cnt_r     <= {RHW{1'b0}};
         frame_cnt_r   <= {FHW{1'b0}};
         o_dval        <= 1'b0;
         o_data        <= {DBIT{1'b0}};
         o_hole        <= 1'b0;
         o_sol         <= 1'b0;
         o_eol         <= 1'b0;
         o_sof         <= 1'b0;
         o_eof         <= 1'b0;
         o_row_holes   <= {RHW{1'b0}};
         o_frame_holes <= {FHW{1'b0}};
         o_stat_vld    <= 1'b0;
      end else begin
         o_dval     <= i_dval;
         o_stat_vld <= o_dval & o_eol;
         if (i_dval) begin
            col_r       <= col_s;
            row_r       <= row_s;
            row_cnt_r   <= row_sum_s;
            frame_cnt_r <= frame_sum_s;
            o_data      <= data_s;
            o_hole      <= hole_s;
            o_sol       <= sol_s;
            o_eol       <= eol_s;
            o_sof       <= sof_s;
            o_eof       <= eof_s;
            if (!hole_s) begin
               last_r <= i_data;
            end
            if (eol_s) begin
               o_row_holes <= row_sum_s;
            end
            if (eof_s) begin
               o_frame_holes <= frame_sum_s;
            end
         end
      end
   end

endmodule

// File: tb/tb_disparity_hole_fill.sv
// Scoreboard bench for disparity_hole_fill: a short-row (M=5,R=3) and a full-row (M=450,R=3)
// instance share one stimulus stream; a behavioural model queues expected outputs per instance.
`timescale 1ns/1ps
module tb_disparity_hole_fill;

   localparam int FILL = 0;

   // flags = {hole, sol, eol, sof, eof}
   typedef struct packed {
      logic [5:0] data;
      logic [4:0] flags;
      int         rh;
      int         fh;
   } exp_t;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_en_fill = 1'b0;
   logic       i_dval = 1'b0;
   logic [5:0] i_data = 6'd0;

   logic        s_dval, s_hole, s_sol, s_eol, s_sof, s_eof, s_stat;
   logic [5:0]  s_data;
   logic [2:0]  s_rh;
   logic [3:0]  s_fh;
   logic        l_dval, l_hole, l_sol, l_eol, l_sof, l_eof, l_stat;
   logic [5:0]  l_data;
   logic [8:0]  l_rh;
   logic [10:0] l_fh;

   disparity_hole_fill #(.D(64), .M(5), .R(3), .FILL_DEFAULT(FILL)) dut_s (
      .i_clk(i_clk), .i_rst(i_rst), .i_en_fill(i_en_fill), .i_dval(i_dval), .i_data(i_data),
      .o_dval(s_dval), .o_data(s_data), .o_hole(s_hole), .o_sol(s_sol), .o_eol(s_eol),
      .o_sof(s_sof), .o_eof(s_eof), .o_row_holes(s_rh), .o_frame_holes(s_fh), .o_stat_vld(s_stat));

   disparity_hole_fill #(.D(64), .M(450), .R(3), .FILL_DEFAULT(FILL)) dut_l (
      .i_clk(i_clk), .i_rst(i_rst), .i_en_fill(i_en_fill), .i_dval(i_dval), .i_data(i_data),
      .o_dval(l_dval), .o_data(l_data), .o_hole(l_hole), .o_sol(l_sol), .o_eol(l_eol),
      .o_sof(l_sof), .o_eof(l_eof), .o_row_holes(l_rh), .o_frame_holes(l_fh), .o_stat_vld(l_stat));

   exp_t       q [2][$];
   int         m_col [2];
   int         m_row [2];
   int         m_rc [2];
   int         m_fc [2];
   logic       m_in [2];
   logic [5:0] m_last [2];
   exp_t       last_e [2];
   logic [31:0] exp_rh [2];
   logic [31:0] exp_fh [2];
   logic       prev_eol [2];
   logic       rst_q = 1'b1;
   int n_err = 0;
   int n_chk = 0;
   int sof_c = 0;
   int eof_c = 0;
   int dv_c = 0;
   int row_dv = 0;
   int holes_c = 0;

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) rst_q <= i_rst;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_step(input int k, input int m, input int r, input logic en, input logic [5:0] d);
      exp_t e;
      logic sol, eol, sof, eof, hole;
      sol  = (m_col[k] == 0);
      eol  = (m_col[k] == m - 1);
      sof  = sol && (m_row[k] == 0);
      eof  = eol && (m_row[k] == r - 1);
      hole = (d == 6'd0);
      if (sol) m_rc[k] = 0;
      if (sof) m_fc[k] = 0;
      if (hole) begin
         m_rc[k]++;
         m_fc[k]++;
         e.data = en ? (m_in[k] ? m_last[k] : 6'(FILL)) : 6'd0;
      end else begin
         e.data    = d;
         m_last[k] = d;
         m_in[k]   = 1'b1;
      end
      if (eol) m_in[k] = 1'b0;
      e.flags = {hole, sol, eol, sof, eof};
      e.rh    = m_rc[k];
      e.fh    = m_fc[k];
      q[k].push_back(e);
      if (eol) begin
         m_col[k] = 0;
         m_row[k] = (m_row[k] == r - 1) ? 0 : m_row[k] + 1;
      end else begin
         m_col[k]++;
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_col[k]  = 0;
         m_row[k]  = 0;
         m_rc[k]   = 0;
         m_fc[k]   = 0;
         m_in[k]   = 1'b0;
         m_last[k] = 6'(FILL);
         q[k].delete();
      end
   endtask

   task automatic drive(input logic en, input logic [5:0] d);
      i_en_fill = en;
      i_dval    = 1'b1;
      i_data    = d;
      model_step(0, 5, 3, en, d);
      model_step(1, 450, 3, en, d);
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         i_dval    = 1'b0;
         i_data    = 6'($urandom_range(0, 63));
         i_en_fill = 1'($urandom_range(0, 1));
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic do_reset();
      idle(1);
      i_rst = 1'b1;
      model_reset();
      repeat (2) begin
         @(posedge i_clk);
         #1;
      end
      i_rst = 1'b0;
   endtask

   function automatic logic [5:0] rand_pix();
      if ($urandom_range(0, 2) == 0) return 6'd0;
      return 6'($urandom_range(1, 63));
   endfunction

   task automatic mon(input int k, input logic dv, input logic [5:0] dat, input logic [4:0] fl,
                      input logic [31:0] rh, input logic [31:0] fh, input logic st);
      exp_t  e;
      string p;
      p = (k == 0) ? "s_" : "l_";
      if (rst_q) begin
         chk({p, "rst_dval"}, 32'(dv), 32'd0);
         chk({p, "rst_data"}, 32'(dat), 32'd0);
         chk({p, "rst_flags"}, 32'(fl), 32'd0);
         chk({p, "rst_row_holes"}, rh, 32'd0);
         chk({p, "rst_frame_holes"}, fh, 32'd0);
         chk({p, "rst_stat_vld"}, 32'(st), 32'd0);
         last_e[k]   = '0;
         exp_rh[k]   = 32'd0;
         exp_fh[k]   = 32'd0;
         prev_eol[k] = 1'b0;
         if (k == 1) row_dv = 0;
      end else begin
         chk({p, "stat_vld"}, 32'(st), 32'(prev_eol[k]));
         if (dv) begin
            if (q[k].size() == 0) begin
               chk({p, "unexpected_dval"}, 32'd1, 32'd0);
               prev_eol[k] = 1'b0;
            end else begin
               e = q[k].pop_front();
               chk({p, "data"}, 32'(dat), 32'(e.data));
               chk({p, "flags"}, 32'(fl), 32'(e.flags));
               if (e.flags[2]) exp_rh[k] = e.rh;
               if (e.flags[0]) exp_fh[k] = e.fh;
               last_e[k]   = e;
               prev_eol[k] = e.flags[2];
               if (k == 1) begin
                  dv_c++;
                  if (fl[3]) row_dv = 1;
                  else row_dv++;
                  if (fl[1]) sof_c++;
                  if (fl[0]) eof_c++;
                  if (fl[2]) chk("l_row_len", 32'(row_dv), 32'd450);
               end
            end
         end else begin
            chk({p, "hold_data"}, 32'(dat), 32'(last_e[k].data));
            chk({p, "hold_flags"}, 32'(fl), 32'(last_e[k].flags));
            prev_eol[k] = 1'b0;
         end
         chk({p, "row_holes"}, rh, exp_rh[k]);
         chk({p, "frame_holes"}, fh, exp_fh[k]);
      end
   endtask

   initial begin
      forever begin
         @(negedge i_clk);
         mon(0, s_dval, s_data, {s_hole, s_sol, s_eol, s_sof, s_eof}, 32'(s_rh), 32'(s_fh), s_stat);
         mon(1, l_dval, l_data, {l_hole, l_sol, l_eol, l_sof, l_eof}, 32'(l_rh), 32'(l_fh), l_stat);
      end
   end

   initial begin
      logic [5:0] t1 [5];
      logic [5:0] t2 [10];
      logic [5:0] d;
      t1 = '{6'd5, 6'd0, 6'd0, 6'd7, 6'd0};
      t2 = '{6'd0, 6'd0, 6'd9, 6'd3, 6'd0, 6'd0, 6'd2, 6'd0, 6'd0, 6'd0};
      model_reset();
      repeat (3) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      idle(2);

      // fill on, then start-of-row default and no carry across rows
      for (int i = 0; i < 5; i++) drive(1'b1, t1[i]);
      idle(3);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, t2[i]);
         if (i == 3) idle(2);
      end
      idle(2);

      // pass-through row, then fill switched on at the hole of the next row
      drive(1'b0, 6'd4); drive(1'b0, 6'd0); drive(1'b0, 6'd6); drive(1'b0, 6'd1); drive(1'b0, 6'd1);
      drive(1'b0, 6'd4); drive(1'b1, 6'd0); drive(1'b0, 6'd0); drive(1'b0, 6'd5); drive(1'b1, 6'd0);
      idle(2);

      // reset at column 200 of row 1
      do_reset();
      for (int i = 0; i < 650; i++) drive(1'($urandom_range(0, 1)), rand_pix());
      do_reset();
      for (int i = 0; i < 8; i++) drive(1'b1, rand_pix());
      idle(2);

      // full frame with random gaps
      do_reset();
      sof_c = 0; eof_c = 0; dv_c = 0; holes_c = 0;
      for (int i = 0; i < 1350; i++) begin
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
         d = rand_pix();
         if (d == 6'd0) holes_c++;
         drive(1'($urandom_range(0, 1)), d);
      end
      idle(3);
      chk("l_sof_count", 32'(sof_c), 32'd1);
      chk("l_eof_count", 32'(eof_c), 32'd1);
      chk("l_dval_count", 32'(dv_c), 32'd1350);
      chk("l_frame_holes_total", 32'(l_fh), 32'(holes_c));

      // all-zero frame
      do_reset();
      for (int i = 0; i < 1350; i++) drive(1'($urandom_range(0, 1)), 6'd0);
      idle(3);
      chk("l_zero_row_holes", 32'(l_rh), 32'd450);
      chk("l_zero_frame_holes", 32'(l_fh), 32'd1350);
      chk("s_zero_row_holes", 32'(s_rh), 32'd5);
      chk("s_zero_frame_holes", 32'(s_fh), 32'd15);

      chk("s_queue_empty", 32'(q[0].size()), 32'd0);
      chk("l_queue_empty", 32'(q[1].size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/disparity_hole_fill.md
Name: disparity_hole_fill

Overview:
- Post-processing stage directly downstream of the stereo matching core.
- Consumes the raw disparity stream (valid strobe plus DBIT-bit disparity). Disparities the L/R consistency check rejected arrive coded as 0.
- Replaces each rejected pixel with the last valid disparity on the same row.
- Tags start/end of line and frame, and reports per-row and per-frame hole counts to the display/host interface.

Parameters:
- D, 64, disparity range; DBIT = $clog2(D) is the data width.
- M, 450, pixels per row.
- R, 375, rows per frame.
- FILL_DEFAULT, 0, fill value used when no valid disparity has yet been seen on the current row.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_en_fill  in  1  1 = hole filling enabled; 0 = pass-through. Sampled per pixel.
- i_dval  in  1  input disparity valid.
- i_data  in  DBIT  input disparity; 0 = invalid (hole).
- o_dval  out  1  output valid.
- o_data  out  DBIT  filled disparity.
- o_hole  out  1  current output pixel was a hole on input.
- o_sol  out  1  first pixel of a row, qualified by o_dval.
- o_eol  out  1  last pixel of a row, qualified by o_dval.
- o_sof  out  1  first pixel of a frame, qualified by o_dval.
- o_eof  out  1  last pixel of a frame, qualified by o_dval.
- o_row_holes  out  $clog2(M+1)  hole count of the row just finished; updates with o_eol.
- o_frame_holes  out  $clog2(M*R+1)  hole count of the frame just finished; updates with o_eof.
- o_stat_vld  out  1  one-cycle pulse, the cycle after o_eol, when o_row_holes is updated.

Behaviour:
- Latency: exactly 1 cycle, i_dval -> o_dval.
- No back-pressure; a new pixel is accepted on any cycle. Gaps (i_dval = 0) are allowed anywhere.
- Synchronous reset, i_rst = 1 at a clock edge:
  - all outputs go to 0, including o_row_holes and o_frame_holes;
  - column and row counters go to 0;
  - last-valid register goes to FILL_DEFAULT;
  - FSM goes to ROW_START.
- Reset mid-row discards the partial row. The next accepted pixel is column 0, row 0.
- Column counter: 0..M-1, advances on each accepted pixel, wraps to 0 after M-1.
- Row counter: advances on column wrap; 0..R-1, wraps to 0 after R-1.
- Marker flags:
  - o_sol = 1 when col == 0; o_eol = 1 when col == M-1.
  - o_sof = 1 when col == 0 and row == 0; o_eof = 1 when col == M-1 and row == R-1.
- FSM states and transitions:
  - ROW_START: no valid pixel seen yet on this row. Hole output = FILL_DEFAULT. A valid pixel moves to IN_ROW.
  - IN_ROW: hole output = last-valid register.
  - From either state, the eol pixel returns to ROW_START for the next pixel.
- Per accepted pixel:
  - Valid input (i_data != 0): o_data = i_data; last-valid register is loaded; o_hole = 0.
  - Hole (i_data == 0) with i_en_fill = 1: o_data = fill value for the current state; o_hole = 1.
  - Hole with i_en_fill = 0: o_data = 0; o_hole = 1. Last-valid tracking continues.
- Hole counters:
  - The row counter increments on each hole and clears at start of row. On the eol pixel it is transferred to o_row_holes, including that pixel's own contribution.
  - The frame counter follows the same rule with frame boundaries. It is sized so it cannot saturate.
- Edge cases:
  - M = 1: o_sol and o_eol are both asserted on every pixel.
  - i_dval = 0: o_dval = 0; o_data, o_hole and all markers hold their last values.

Test Plan:
- Reset, then row [5,0,0,7,0] with M=5, fill on -> o_data [5,5,5,7,7], o_hole [0,1,1,0,1], o_row_holes=3, o_stat_vld one cycle after o_eol.
- Row starting [0,0,9], FILL_DEFAULT=0 -> o_data [0,0,9]. Next row [0,...] -> first output 0, not 9 (no carry across rows).
- i_en_fill=0, row [4,0,6] -> o_data [4,0,6], o_hole [0,1,0]. Toggle to 1 at the hole of the next row [4,0] -> 4 is used.
- Random i_dval gaps over a full M=450, R=3 frame -> o_sof once, o_eof once, exactly 450 o_dval per row, o_frame_holes equals the scoreboard count.
- i_rst asserted at column 200 of row 1 -> next accepted pixel flagged o_sof=1 and o_sol=1; no stale fill value, all stats reported 0.
- All-zero frame -> every o_data = FILL_DEFAULT, o_row_holes = M each row, o_frame_holes = M*R.
